// File: rtl/ssb_mod_core.sv
// Single-sideband combiner: delays I to line up with the externally Hilbert-filtered Q,
// pairs one I with one Q, and forms (I +/- Q)/2 with optional rounding and saturation.
module ssb_mod_core #(
  parameter int unsigned W     = 24,
  parameter int unsigned DELAY = 25,
  parameter bit          ROUND = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  input  logic [W-1:0] q_data,
  input  logic         q_valid,
  input  logic         usb,
  input  logic         clr_err,
  output logic [W-1:0] ssb_out,
  output logic         ssb_valid,
  output logic         primed,
  output logic         err_overrun,
  output logic         err_underrun
);
  typedef enum logic {S_FILL, S_RUN} state_t;

  localparam state_t RESET_STATE = (DELAY == 0) ? S_RUN : S_FILL;
  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  state_t              r_state, w_next_state;
  logic [8:0]          r_fill_cnt;
  logic [W-1:0]        w_delayed, r_hold_i, w_op_i, w_sat;
  logic                r_hold_usb, w_op_usb, r_pending, w_fire;
  logic signed [W+1:0] w_a, w_b, w_sum, w_rnd;

  always_comb begin
    w_next_state = r_state;
    if (r_state == S_FILL && i_valid && (r_fill_cnt + 9'd1 == 9'(DELAY)))
      w_next_state = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= RESET_STATE;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FILL && i_valid) r_fill_cnt <= r_fill_cnt + 9'd1;
    end
  end

  assign primed = (r_state == S_RUN);

  generate
    if (DELAY == 0) begin : g_bypass
      assign w_delayed = i_data;
    end else begin : g_line
      localparam int unsigned  PW   = (DELAY > 1) ? $clog2(DELAY) : 1;
      localparam logic [PW-1:0] LAST = PW'(DELAY - 1);
      logic [W-1:0]  r_ram [DELAY];
      logic [PW-1:0] r_wr_ptr;

      // RAM is never cleared; stale contents stay masked until the FSM reaches RUN.
      always_ff @(posedge clk) begin
        if (reset_n && i_valid) r_ram[r_wr_ptr] <= i_data;
      end

      always_ff @(posedge clk) begin
        if (!reset_n)     r_wr_ptr <= '0;
        else if (i_valid) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      end

      assign w_delayed = (r_state == S_RUN) ? r_ram[r_wr_ptr] : '0;
    end
  endgenerate

  // A same-cycle I strobe bypasses the hold registers.
  assign w_fire   = q_valid && (r_pending || i_valid);
  assign w_op_i   = i_valid ? w_delayed : r_hold_i;
  assign w_op_usb = i_valid ? usb : r_hold_usb;

  always_comb begin
    w_a   = {{2{w_op_i[W-1]}}, w_op_i};
    w_b   = {{2{q_data[W-1]}}, q_data};
    w_sum = w_op_usb ? (w_a - w_b) : (w_a + w_b);
    w_rnd = ROUND ? ((w_sum + (W+2)'(1)) >>> 1) : (w_sum >>> 1);
    if (w_rnd > SAT_MAX)      w_sat = SAT_MAX[W-1:0];
    else if (w_rnd < SAT_MIN) w_sat = SAT_MIN[W-1:0];
    else                      w_sat = w_rnd[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_i     <= '0;
      r_hold_usb   <= 1'b0;
      r_pending    <= 1'b0;
      ssb_out      <= '0;
      ssb_valid    <= 1'b0;
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      ssb_valid <= w_fire;
      if (w_fire) ssb_out <= w_sat;
      if (i_valid) begin
        r_hold_i   <= w_delayed;
        r_hold_usb <= usb;
      end
      if (w_fire)       r_pending <= 1'b0;
      else if (i_valid) r_pending <= 1'b1;
      if (clr_err) begin
        err_overrun  <= 1'b0;
        err_underrun <= 1'b0;
      end
      if (i_valid && !q_valid && r_pending) err_overrun  <= 1'b1;
      if (q_valid && !r_pending && !i_valid) err_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ssb_mod_core.sv
// Scoreboard bench: four configurations share one stimulus stream; a history-based
// reference model predicts each output, a negedge monitor pops and compares.
module tb_ssb_mod_core;
  localparam int W  = 24;
  localparam int NI = 4;
  localparam int DL [NI] = '{2, 0, 0, 25};
  localparam bit RD [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic         clk, reset_n, i_valid, q_valid, usb, clr_err;
  logic [W-1:0] i_data, q_data;
  logic [W-1:0] ssb_out [NI];
  logic         ssb_valid [NI], primed [NI], err_o [NI], err_u [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ssb_mod_core #(.W(W), .DELAY(DL[g]), .ROUND(RD[g])) u_dut (
      .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
      .q_data(q_data), .q_valid(q_valid), .usb(usb), .clr_err(clr_err),
      .ssb_out(ssb_out[g]), .ssb_valid(ssb_valid[g]), .primed(primed[g]),
      .err_overrun(err_o[g]), .err_underrun(err_u[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint val; int cyc; } exp_t;

  int     checks = 0, failures = 0, cyc = 0;
  longint ihist [$];
  bit     m_pend, m_husb, m_eo, m_eu, m_fire;
  longint m_hold [NI], m_out [NI], m_dly [NI];
  exp_t   expq [NI][$];

  task automatic chk(string name, int k, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  function automatic longint combine(longint a, longint q, bit u, bit rnd);
    longint s, r, mx, mn;
    mx = (longint'(1) << (W-1)) - 1;
    mn = -(longint'(1) << (W-1));
    s  = u ? a - q : a + q;
    if (rnd) s = s + 1;
    r = (s >= 0) ? s / 2 : -((1 - s) / 2);
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
  endfunction

  // Reference model: delayed sample = I from DELAY strobes ago since reset, else 0.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      ihist.delete();
      m_pend = 0; m_husb = 0; m_eo = 0; m_eu = 0;
      for (int k = 0; k < NI; k++) begin m_hold[k] = 0; m_out[k] = 0; end
    end else begin
      m_fire = q_valid && (m_pend || i_valid);
      if (i_valid) begin
        ihist.push_back(longint'($signed(i_data)));
        for (int k = 0; k < NI; k++)
          m_dly[k] = (ihist.size() - 1 >= DL[k]) ? ihist[ihist.size() - 1 - DL[k]] : 0;
      end
      if (clr_err) begin m_eo = 0; m_eu = 0; end
      if (m_fire) begin
        for (int k = 0; k < NI; k++) begin
          m_out[k] = combine(i_valid ? m_dly[k] : m_hold[k], longint'($signed(q_data)),
                             i_valid ? usb : m_husb, RD[k]);
          expq[k].push_back('{m_out[k], cyc});
        end
        m_pend = 0;
      end else if (i_valid) begin
        if (m_pend) m_eo = 1;
        for (int k = 0; k < NI; k++) m_hold[k] = m_dly[k];
        m_husb = usb;
        m_pend = 1;
      end else if (q_valid) begin
        m_eu = 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit   want;
      exp_t e;
      want = (expq[k].size() != 0) && (expq[k][0].cyc <= cyc);
      chk("ssb_valid", k, ssb_valid[k], want);
      if (want) begin
        e = expq[k].pop_front();
        if (ssb_valid[k]) begin
          chk("ssb_value", k, longint'($signed(ssb_out[k])), e.val);
          chk("ssb_latency", k, cyc, e.cyc);
        end
      end
      chk("ssb_out_held", k, longint'($signed(ssb_out[k])), m_out[k]);
      chk("primed", k, primed[k], ihist.size() >= DL[k]);
      chk("err_overrun", k, err_o[k], m_eo);
      chk("err_underrun", k, err_u[k], m_eu);
    end
  end

  task automatic tick();
    @(negedge clk);
    i_valid = 0; q_valid = 0; clr_err = 0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send_i(int d, bit u);
    i_valid = 1; i_data = d[W-1:0]; usb = u;
    tick();
  endtask

  task automatic send_q(int d);
    q_valid = 1; q_data = d[W-1:0];
    tick();
  endtask

  task automatic do_reset(int n);
    reset_n = 0; idle(n); reset_n = 1;
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 7))
      0:       return (1 << (W-1)) - 1;
      1:       return -(1 << (W-1));
      2:       return int'($urandom_range(0, 7)) - 4;
      default: return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    endcase
  endfunction

  initial begin
    reset_n = 0; i_valid = 0; q_valid = 0; usb = 0; clr_err = 0;
    i_data = '0; q_data = '0;
    @(negedge clk);
    do_reset(3);

    // Priming with DELAY=2: outputs 0, 0, 50 on dut0
    send_i(100, 0); chk("prime_after_1st", 0, primed[0], 0);
    idle(4); send_q(0); chk("prime_valid_lat", 0, ssb_valid[0], 1);
    chk("prime_out1", 0, longint'($signed(ssb_out[0])), 0);
    send_i(200, 0); chk("prime_after_2nd", 0, primed[0], 1);
    idle(4); send_q(0); chk("prime_out2", 0, longint'($signed(ssb_out[0])), 0);
    send_i(300, 0); idle(4); send_q(0);
    chk("prime_out3", 0, longint'($signed(ssb_out[0])), 50);
    idle(2);

    // Sideband on DELAY=0
    send_i(1000, 0); idle(2); send_q(400); chk("lsb", 1, longint'($signed(ssb_out[1])), 700);
    send_i(1000, 1); idle(2); send_q(400); chk("usb", 1, longint'($signed(ssb_out[1])), 300);
    send_i(1000, 1); usb = 0; idle(2); send_q(400);
    chk("usb_latched", 1, longint'($signed(ssb_out[1])), 300);

    // Rounding and saturation
    send_i(3, 0); send_q(0);
    chk("round_pos", 1, longint'($signed(ssb_out[1])), 2);
    chk("trunc_pos", 2, longint'($signed(ssb_out[2])), 1);
    send_i(-3, 0); send_q(0);
    chk("round_neg", 1, longint'($signed(ssb_out[1])), -1);
    chk("trunc_neg", 2, longint'($signed(ssb_out[2])), -2);
    send_i(8388607, 1); send_q(-8388608);
    chk("sat_max", 1, longint'($signed(ssb_out[1])), 8388607);
    idle(1);

    // Error flags
    send_i(10, 0); send_i(20, 0); chk("overrun_set", 1, err_o[1], 1);
    send_q(0); chk("overrun_pair2", 1, longint'($signed(ssb_out[1])), 10);
    send_q(5); chk("underrun_set", 1, err_u[1], 1);
    chk("underrun_noval", 1, ssb_valid[1], 0);
    clr_err = 1; tick();
    chk("clr_overrun", 1, err_o[1], 0); chk("clr_underrun", 1, err_u[1], 0);
    clr_err = 1; q_valid = 1; q_data = 1; tick();
    chk("clr_vs_set", 1, err_u[1], 1);
    clr_err = 1; tick();

    // Simultaneous I/Q, then reset with a pair in flight
    i_valid = 1; q_valid = 1; i_data = 10; q_data = 4; usb = 0; tick();
    chk("simul", 1, longint'($signed(ssb_out[1])), 7);
    send_i(77, 0); do_reset(3); send_q(1);
    chk("reset_noval", 0, ssb_valid[0], 0); chk("reset_unprimed", 0, primed[0], 0);
    send_i(500, 0); send_q(0); chk("refill_masked", 0, longint'($signed(ssb_out[0])), 0);
    clr_err = 1; tick();

    // Random well-formed pairs with occasional faults and mid-sample usb flips
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 4);
      i_valid = 1; i_data = rnd_sample(); usb = $urandom_range(0, 1);
      if (gap == 0) begin
        q_valid = 1; q_data = rnd_sample(); tick();
      end else begin
        tick();
        repeat (gap - 1) begin usb = $urandom_range(0, 1); tick(); end
        if ($urandom_range(0, 9) != 0) send_q(rnd_sample());
        if ($urandom_range(0, 19) == 0) send_q(rnd_sample());
      end
      if ($urandom_range(0, 15) == 0) begin clr_err = 1; tick(); end
    end

    // Random unconstrained traffic
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 3) == 0); i_data = rnd_sample();
      q_valid = ($urandom_range(0, 3) == 0); q_data = rnd_sample();
      usb     = $urandom_range(0, 1);
      clr_err = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset_n = 1;

    // Reset after random activity
    i_valid = 1; q_valid = 1; i_data = rnd_sample(); q_data = rnd_sample();
    reset_n = 0; tick(); idle(2);
    for (int k = 0; k < NI; k++) begin
      chk("rst_out", k, longint'($signed(ssb_out[k])), 0);
      chk("rst_valid", k, ssb_valid[k], 0);
      chk("rst_primed", k, primed[k], DL[k] == 0);
      chk("rst_eo", k, err_o[k], 0);
      chk("rst_eu", k, err_u[k], 0);
    end
    reset_n = 1;
    idle(3);
    for (int k = 0; k < NI; k++) chk("sb_drained", k, expq[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
